// File: rtl/cpu_cmd_sequencer.sv
// cpu_cmd_sequencer: queues packed cpu commands from a valid/ready stream, drives
// them onto the cpu register-file/ALU port one at a time, captures the cpu result
// after a fixed latency and returns it on a tagged response stream.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command stream handshake (cmd_ready = !full, registered)
//   cmd_data[47:0]             {opsel[1:0], outsel[1:0], asel, bsel, addrA[4:0], addrB[4:0], dataIn[31:0]}
//   rsp_valid/rsp_ready        response stream handshake
//   rsp_data, rsp_over         captured cpu outPut / over
//   rsp_tag                    command sequence number, wraps 255 -> 0
//   busy                       FIFO non-empty or a command in flight
//   addressA .. oen            cpu port, all zero while no command is driven
//   outPut, over               cpu result, sampled only at the capture edge
module cpu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int HOLD  = 1,
   parameter int LAT   = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [47:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_over,
   output logic [7:0]  rsp_tag,
   output logic        busy,
   output logic [4:0]  addressA,
   output logic [4:0]  addressB,
   output logic [31:0] dataIn,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  opsel,
   output logic [1:0]  outsel,
   output logic        oen,
   input  logic [31:0] outPut,
   input  logic        over
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(HOLD + LAT + 1);
   // cnt value seen at the capture edge E0+HOLD+LAT (cnt is 0 right after E0)
   localparam logic [CW-1:0] CLAST = CW'(HOLD + LAT - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t          state, state_n;
   logic [47:0]     mem [DEPTH];
   logic [AW-1:0]   wp, rp;
   logic [AW:0]     count, count_n;
   logic [CW-1:0]   cnt;
   logic [7:0]      seq;
   logic            push, pop, cap;

   assign busy = (count != '0) || (state != IDLE);

   always_comb begin
      push    = cmd_valid && cmd_ready;
      // pop only from IDLE or on a response handshake, so RESP can go straight back to DRIVE
      pop     = (count != '0) && (state == IDLE || (state == RESP && rsp_ready));
      cap     = (state == DRIVE) && (cnt == CLAST);
      count_n = count + (AW+1)'(push) - (AW+1)'(pop);
      state_n = state;
      case (state)
         IDLE:    state_n = pop ? DRIVE : IDLE;
         DRIVE:   state_n = cap ? RESP : DRIVE;
         RESP:    state_n = rsp_ready ? (pop ? DRIVE : IDLE) : RESP;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;

   always_ff @(posedge clk)
      if (push) mem[wp] <= cmd_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         cmd_ready <= 1'b0;
         cnt       <= '0;
         seq       <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_over  <= 1'b0;
         rsp_tag   <= '0;
         {opsel, outsel, asel, bsel, addressA, addressB, dataIn, oen} <= '0;
      end else begin
         count     <= count_n;
         cmd_ready <= count_n != (AW+1)'(DEPTH);
         if (push) wp <= wp + AW'(1);
         if (pop) begin
            rp  <= rp + AW'(1);
            {opsel, outsel, asel, bsel, addressA, addressB, dataIn} <= mem[rp];
            oen <= 1'b1;
            cnt <= '0;
         end else if (state == DRIVE) begin
            cnt <= cnt + CW'(1);
            if (cap) {opsel, outsel, asel, bsel, addressA, addressB, dataIn, oen} <= '0;
         end
         if (cap) begin
            rsp_data  <= outPut;
            rsp_over  <= over;
            rsp_tag   <= seq;
            rsp_valid <= 1'b1;
            seq       <= seq + 8'd1;
         end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// tb_cpu_cmd_sequencer: directed self-checking bench with a behavioural cpu
// (register file + adder) attached to the sequencer's cpu port.
module tb_cpu_cmd_sequencer;
   logic        clk = 0, rst_n = 1;
   logic        cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_over, busy;
   logic [47:0] cmd_data = '0;
   logic [31:0] rsp_data, dataIn, outPut;
   logic [7:0]  rsp_tag;
   logic [4:0]  addressA, addressB;
   logic        asel, bsel, oen, over;
   logic [1:0]  opsel, outsel;
   int          total = 0, passed = 0;

   cpu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_over(rsp_over),
      .rsp_tag(rsp_tag), .busy(busy), .addressA(addressA), .addressB(addressB), .dataIn(dataIn),
      .asel(asel), .bsel(bsel), .opsel(opsel), .outsel(outsel), .oen(oen), .outPut(outPut), .over(over)
   );

   always #5 clk = ~clk;

   // cpu model: opsel 01 stores dataIn into r[addressB]; opsel 00 adds the operands
   // (register when sel=1, else dataIn); outsel 01 routes the sum, over is the carry out
   logic [31:0] rf [32];
   logic [31:0] a_op, b_op;
   logic [32:0] sum;
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always_comb begin
      a_op   = asel ? rf[addressA] : dataIn;
      b_op   = bsel ? rf[addressB] : dataIn;
      sum    = {1'b0, a_op} + {1'b0, b_op};
      outPut = (oen && outsel == 2'b01) ? sum[31:0] : 32'h0;
      over   = oen && opsel == 2'b00 && sum[32];
   end
   always @(posedge clk) if (oen && opsel == 2'b01) rf[addressB] <= dataIn;

   function automatic logic [47:0] mk(input logic [1:0] op, input logic [1:0] os, input logic a,
                                      input logic b, input logic [4:0] ra, input logic [4:0] rb,
                                      input logic [31:0] d);
      return {op, os, a, b, ra, rb, d};
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0; cmd_valid = 0; rsp_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [47:0] c);
      int w = 0;
      cmd_valid = 1; cmd_data = c;
      while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (!cmd_ready) begin total++; $display("FAIL send_timeout cmd_ready stuck at 0, want 1"); end
      else begin @(posedge clk); #1; end
      cmd_valid = 0;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output logic o, output logic [7:0] t);
      int w = 0;
      while (!rsp_valid && w < 100) begin @(posedge clk); #1; w++; end
      if (!rsp_valid) begin total++; $display("FAIL rsp_timeout rsp_valid stuck at 0, want 1"); end
      d = rsp_data; o = rsp_over; t = rsp_tag;
      rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
   endtask

   task automatic test_reset();
      #2 rst_n = 0;
      #1;
      total++; if (oen !== 1'b0) $display("FAIL reset_oen got %0b want 0", oen); else passed++;
      total++; if ({opsel, outsel, asel, bsel, addressA, addressB, dataIn} !== 48'h0)
         $display("FAIL reset_cpu_port got %h want 0", {opsel, outsel, asel, bsel, addressA, addressB, dataIn}); else passed++;
      total++; if ({rsp_valid, rsp_over, rsp_data, rsp_tag} !== 42'h0)
         $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_over, rsp_data, rsp_tag}); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); else passed++;
   endtask

   task automatic test_store();
      logic [31:0] d; logic o; logic [7:0] t; int n = 0, bad = 0;
      send(mk(2'b01, 2'b00, 0, 0, 5'd0, 5'd0, 32'h5));
      repeat (4) begin
         @(posedge clk); #1;
         if (oen) begin n++; if (addressB !== 5'd0 || dataIn !== 32'h5 || opsel !== 2'b01) bad++; end
      end
      total++; if (n !== 2) $display("FAIL store_oen_cycles got %0d want 2", n); else passed++;
      total++; if (bad !== 0) $display("FAIL store_port_fields got %0d bad cycles want 0", bad); else passed++;
      wait_rsp(d, o, t);
      total++; if (t !== 8'd0) $display("FAIL store_tag got %0d want 0", t); else passed++;
      total++; if (rf[0] !== 32'h5) $display("FAIL store_r0 got %h want 00000005", rf[0]); else passed++;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL store_idle got valid=%0b busy=%0b want 0 0", rsp_valid, busy); else passed++;
   endtask

   task automatic test_add();
      logic [31:0] d; logic o; logic [7:0] t;
      send(mk(2'b01, 2'b00, 0, 0, 5'd0, 5'd2, 32'h5555_5555));
      wait_rsp(d, o, t);
      send(mk(2'b00, 2'b01, 1, 1, 5'd2, 5'd0, 32'h0));
      wait_rsp(d, o, t);
      total++; if (d !== 32'h5555_555A) $display("FAIL add_data got %h want 5555555a", d); else passed++;
      total++; if (o !== 1'b0) $display("FAIL add_over got %0b want 0", o); else passed++;
      total++; if (t !== 8'd2) $display("FAIL add_tag got %0d want 2", t); else passed++;
   endtask

   task automatic test_overflow();
      logic [31:0] d; logic o; logic [7:0] t;
      send(mk(2'b01, 2'b00, 0, 0, 5'd0, 5'd5, 32'hFFFF_FFFF));
      wait_rsp(d, o, t);
      send(mk(2'b01, 2'b00, 0, 0, 5'd0, 5'd8, 32'h1));
      wait_rsp(d, o, t);
      send(mk(2'b00, 2'b01, 1, 1, 5'd5, 5'd8, 32'h0));
      wait_rsp(d, o, t);
      total++; if (d !== 32'h0) $display("FAIL ovf_data got %h want 00000000", d); else passed++;
      total++; if (o !== 1'b1) $display("FAIL ovf_over got %0b want 1", o); else passed++;
      total++; if (t !== 8'd5) $display("FAIL ovf_tag got %0d want 5", t); else passed++;
   endtask

   task automatic test_backpressure();
      int acc = 0, n = 0, bad = 0;
      logic sent;
      logic [31:0] snap_d; logic [7:0] snap_t; logic snap_o;
      logic [7:0] tags [6]; logic [31:0] datas [6];
      do_reset();
      cmd_valid = 1;
      for (int c = 0; c < 12; c++) begin
         cmd_data = mk(2'b00, 2'b01, 0, 0, 5'd0, 5'd0, 32'(acc + 1));
         sent = cmd_ready;
         @(posedge clk); #1;
         if (sent) acc++;
      end
      total++; if (acc !== 5) $display("FAIL bp_accepts got %0d want 5", acc); else passed++;
      total++; if (cmd_ready !== 1'b0) $display("FAIL bp_full_ready got %0b want 0", cmd_ready); else passed++;
      snap_d = rsp_data; snap_t = rsp_tag; snap_o = rsp_over;
      repeat (3) @(posedge clk);
      #1;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== snap_d || rsp_tag !== snap_t || rsp_over !== snap_o || rsp_tag !== 8'd0)
         $display("FAIL bp_frozen got valid=%0b tag=%0d data=%h want 1 0 %h", rsp_valid, rsp_tag, rsp_data, snap_d); else passed++;
      rsp_ready = 1;
      for (int c = 0; c < 80 && n < 6; c++) begin
         if (rsp_valid) begin tags[n] = rsp_tag; datas[n] = rsp_data; n++; end
         sent = cmd_valid && cmd_ready;
         @(posedge clk); #1;
         if (sent) cmd_valid = 0;
      end
      total++; if (n !== 6) $display("FAIL bp_count got %0d want 6", n); else passed++;
      for (int i = 0; i < n; i++) if (tags[i] !== 8'(i) || datas[i] !== 32'(2 * (i + 1))) bad++;
      total++; if (bad !== 0) $display("FAIL bp_order got %0d bad responses want 0", bad); else passed++;
      repeat (4) @(posedge clk);
      #1;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL bp_drained got valid=%0b busy=%0b want 0 0", rsp_valid, busy); else passed++;
      rsp_ready = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic o; logic [7:0] t; int seen = 0;
      do_reset();
      send(mk(2'b00, 2'b01, 0, 0, 5'd1, 5'd2, 32'h10));
      send(mk(2'b00, 2'b01, 0, 0, 5'd1, 5'd2, 32'h20));
      @(posedge clk); #1;
      total++; if (oen !== 1'b1) $display("FAIL mid_driving got oen=%0b want 1", oen); else passed++;
      rst_n = 0;
      #1;
      total++; if ({oen, opsel, outsel, asel, bsel, addressA, addressB, dataIn} !== 49'h0)
         $display("FAIL mid_port_reset got %h want 0", {oen, opsel, outsel, asel, bsel, addressA, addressB, dataIn}); else passed++;
      total++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL mid_rsp_reset got valid=%0b busy=%0b want 0 0", rsp_valid, busy); else passed++;
      #3 rst_n = 1;
      rsp_ready = 1;
      repeat (10) begin @(posedge clk); #1; if (rsp_valid) seen++; end
      rsp_ready = 0;
      total++; if (seen !== 0) $display("FAIL mid_no_rsp got %0d responses want 0", seen); else passed++;
      total++; if (busy !== 1'b0 || cmd_ready !== 1'b1)
         $display("FAIL mid_after got busy=%0b ready=%0b want 0 1", busy, cmd_ready); else passed++;
      send(mk(2'b00, 2'b01, 0, 0, 5'd0, 5'd0, 32'h7));
      wait_rsp(d, o, t);
      total++; if (t !== 8'd0 || d !== 32'hE) $display("FAIL mid_next got tag=%0d data=%h want 0 0000000e", t, d); else passed++;
   endtask

   task automatic test_tag_wrap();
      int acc = 0, n = 0, bad = 0, first = 0, last = 0;
      logic sent; logic [7:0] lt; logic [31:0] ld;
      do_reset();
      cmd_valid = 1; rsp_ready = 1;
      for (int c = 0; c < 1200 && n < 257; c++) begin
         cmd_data = mk(2'b00, 2'b01, 0, 0, 5'd0, 5'd0, 32'(acc));
         if (rsp_valid) begin
            if (rsp_tag !== 8'(n)) bad++;
            if (n == 0) first = c;
            last = c; lt = rsp_tag; ld = rsp_data; n++;
         end
         sent = cmd_valid && cmd_ready;
         @(posedge clk); #1;
         if (sent) begin acc++; if (acc == 257) cmd_valid = 0; end
      end
      rsp_ready = 0;
      total++; if (n !== 257) $display("FAIL wrap_count got %0d want 257", n); else passed++;
      total++; if (lt !== 8'd0 || ld !== 32'd512) $display("FAIL wrap_last got tag=%0d data=%0d want 0 512", lt, ld); else passed++;
      total++; if (bad !== 0) $display("FAIL wrap_seq got %0d out-of-order tags want 0", bad); else passed++;
      total++; if (last - first !== 768) $display("FAIL wrap_rate got %0d cycles want 768", last - first); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL wrap_busy got %0b want 0", busy); else passed++;
   endtask

   initial begin
      test_reset();
      test_store();
      test_add();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_tag_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
